// File: rtl/multi_channel_loader.sv
// Multi-channel sample buffer: a load session fills per-channel memories under a
// per-channel enable, and a readout session streams the stored samples back out.
module multi_channel_loader #(
    parameter int CH    = 2,
    parameter int W     = 20,
    parameter int DEPTH = 150,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              start_read,
    input  logic [CH-1:0]     ch_en,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [CH*W-1:0]   data_in,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_last,
    output logic [CH*W-1:0]   data_out,
    output logic [AW-1:0]     addr_out,
    output logic [AW:0]       count,
    output logic              busy,
    output logic              load_done,
    output logic              read_done
);

    typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [W-1:0]  mem [CH][DEPTH];

    logic in_fire;
    logic load_end;
    logic rd_load;
    logic out_fire;
    logic read_end;
    logic read_go;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign in_fire   = (state == LOAD) && in_valid;
    // A load stops on in_last or when the last slot is written, so the pointer never wraps.
    assign load_end  = in_fire && (in_last || (wr_ptr == AW'(DEPTH - 1)));
    assign rd_load   = (state == READ) && (!out_valid || out_ready) && (rd_ptr < count);
    assign out_fire  = (state == READ) && out_valid && out_ready;
    assign read_end  = out_fire && out_last;
    assign read_go   = start_read && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_load) begin
                    state_nxt = LOAD;
                end else if (read_go) begin
                    state_nxt = READ;
                end
            end
            LOAD: begin
                if (load_end) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (read_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            data_out  <= '0;
            addr_out  <= '0;
            load_done <= 1'b0;
            read_done <= 1'b0;
        end else begin
            load_done <= load_end;
            read_done <= read_end;

            if ((state == IDLE) && start_load) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (in_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + (AW+1)'(1);
            end

            // The output register refills whenever it is empty or being drained.
            if (state == IDLE) begin
                rd_ptr <= '0;
            end else if (rd_load) begin
                rd_ptr    <= rd_ptr + (AW+1)'(1);
                out_valid <= 1'b1;
                addr_out  <= rd_ptr[AW-1:0];
                out_last  <= (rd_ptr == (count - (AW+1)'(1)));
                for (int i = 0; i < CH; i++) begin
                    data_out[i*W +: W] <= mem[i][rd_ptr[AW-1:0]];
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset; disabled channels keep old samples.
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            for (int i = 0; i < CH; i++) begin
                if (ch_en[i]) begin
                    mem[i][wr_ptr] <= data_in[i*W +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_loader.sv
// Randomized self-checking bench for multi_channel_loader against a slot-array
// reference model of what each load session leaves in memory.
module tb_multi_channel_loader;

    localparam int CH    = 2;
    localparam int W     = 20;
    localparam int DEPTH = 150;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst;
    logic            start_load;
    logic            start_read;
    logic [CH-1:0]   ch_en;
    logic            in_valid;
    logic            in_last;
    logic [CH*W-1:0] data_in;
    logic            in_ready;
    logic            out_ready;
    logic            out_valid;
    logic            out_last;
    logic [CH*W-1:0] data_out;
    logic [AW-1:0]   addr_out;
    logic [AW:0]     count;
    logic            busy;
    logic            load_done;
    logic            read_done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    modelMem [CH][DEPTH];
    int              modelCount = 0;
    logic [CH*W-1:0] fixedData [$];

    multi_channel_loader #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_read(start_read),
        .ch_en(ch_en), .in_valid(in_valid), .in_last(in_last), .data_in(data_in),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_last(out_last), .data_out(data_out), .addr_out(addr_out),
        .count(count), .busy(busy), .load_done(load_done), .read_done(read_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] expBeat(input int idx);
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = modelMem[c][idx];
        return v;
    endfunction

    task automatic doLoad(input int nbeats, input int lastIdx, input logic [CH-1:0] en, input bit gaps);
        int acc;
        int ng;
        bit ended;
        logic [CH*W-1:0] d;
        acc = 0;
        ended = 0;
        @(negedge clk);
        start_load = 1'b1;
        ch_en = en;
        @(negedge clk);
        start_load = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (ended) begin
                in_valid = 1'b1;
                in_last  = 1'b0;
                data_in  = (CH*W)'({$urandom, $urandom});
                checkOutput("ready_after_end", 64'(in_ready), 64'd0);
                @(negedge clk);
                checkOutput("extra_busy", 64'(busy), 64'd0);
                checkOutput("extra_count", 64'(count), 64'(acc));
                checkOutput("extra_done", 64'(load_done), 64'd0);
                in_valid = 1'b0;
                break;
            end
            ng = gaps ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < ng; g++) begin
                in_valid   = 1'b0;
                start_read = 1'($urandom_range(0, 1));
                checkOutput("gap_ready", 64'(in_ready), 64'd1);
                checkOutput("gap_done", 64'(load_done), 64'd0);
                @(negedge clk);
            end
            checkOutput("in_ready", 64'(in_ready), 64'd1);
            d = (k < fixedData.size()) ? fixedData[k] : (CH*W)'({$urandom, $urandom});
            in_valid   = 1'b1;
            in_last    = (k == lastIdx);
            data_in    = d;
            start_read = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (en[c]) modelMem[c][acc] = d[c*W +: W];
            acc++;
            if (k == lastIdx || acc == DEPTH) begin
                ended      = 1;
                modelCount = acc;
                start_read = 1'b0;
                in_valid   = 1'b0;
                in_last    = 1'b0;
                checkOutput("load_done", 64'(load_done), 64'd1);
                checkOutput("count", 64'(count), 64'(acc));
                checkOutput("busy_end", 64'(busy), 64'd0);
                checkOutput("ready_end", 64'(in_ready), 64'd0);
                @(negedge clk);
                checkOutput("done_pulse", 64'(load_done), 64'd0);
            end else begin
                checkOutput("load_done_early", 64'(load_done), 64'd0);
            end
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        start_read = 1'b0;
        checkOutput("load_ended", 64'(ended), 64'd1);
    endtask

    // mode 0: always ready, 1: random back-pressure, 2: five stall cycles at slot 1
    task automatic doRead(input int mode);
        int idx;
        int stall;
        bit fin;
        bit rdy;
        idx = 0;
        stall = 0;
        fin = 0;
        out_ready = 1'b0;
        @(negedge clk);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        checkOutput("rd_busy", 64'(busy), 64'd1);
        checkOutput("rd_first_idle", 64'(out_valid), 64'd0);
        @(negedge clk);
        for (int cyc = 0; cyc < 4*DEPTH + 20 && !fin; cyc++) begin
            checkOutput("out_valid", 64'(out_valid), 64'd1);
            checkOutput("addr_out", 64'(addr_out), 64'(idx));
            checkOutput("data_out", 64'(data_out), 64'(expBeat(idx)));
            checkOutput("out_last", 64'(out_last), 64'(idx == modelCount - 1));
            checkOutput("read_done_early", 64'(read_done), 64'd0);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (idx == 1 && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            out_ready  = rdy;
            start_load = 1'($urandom_range(0, 1));
            @(negedge clk);
            start_load = 1'b0;
            if (rdy) begin
                if (idx == modelCount - 1) begin
                    fin = 1;
                    checkOutput("read_done", 64'(read_done), 64'd1);
                    checkOutput("rd_end_busy", 64'(busy), 64'd0);
                    checkOutput("rd_end_valid", 64'(out_valid), 64'd0);
                    checkOutput("rd_end_last", 64'(out_last), 64'd0);
                end else begin
                    idx++;
                end
            end
        end
        out_ready = 1'b0;
        checkOutput("read_finished", 64'(fin), 64'd1);
        if (fin) begin
            @(negedge clk);
            checkOutput("read_done_pulse", 64'(read_done), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_load = 1'b0;
        start_read = 1'b0;
        ch_en = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        data_in = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_last", 64'(out_last), 64'd0);
        checkOutput("rst_data", 64'(data_out), 64'd0);
        checkOutput("rst_addr", 64'(addr_out), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_ldone", 64'(load_done), 64'd0);
        checkOutput("rst_rdone", 64'(read_done), 64'd0);
        rst = 1'b0;

        // start_read with an empty buffer must be ignored
        @(negedge clk);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        checkOutput("empty_read_busy", 64'(busy), 64'd0);

        $display("[TB] full-depth load without in_last");
        doLoad(DEPTH + 1, -1, 2'b11, 1'b0);
        doRead(1);

        $display("[TB] three-beat default load and free-running readout");
        fixedData = '{{20'h00001, 20'hAAAAA}, {20'h00002, 20'hBBBBB}, {20'h00003, 20'hCCCCC}};
        doLoad(3, 2, 2'b11, 1'b0);
        fixedData.delete();
        doRead(0);

        $display("[TB] partial reload on channel 0 only");
        doLoad(2, 1, 2'b01, 1'b1);
        doRead(0);

        $display("[TB] random sessions");
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(1, 20);
            doLoad(n, n - 1, CH'($urandom_range(0, 3)), 1'b1);
            doRead(1);
        end
        doLoad(6, 5, 2'b10, 1'b1);
        doRead(2);

        $display("[TB] reset during readout");
        @(negedge clk);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_addr", 64'(addr_out), 64'd1);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelCount = 0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_count", 64'(count), 64'd0);
        checkOutput("abort_rdone", 64'(read_done), 64'd0);
        checkOutput("abort_addr", 64'(addr_out), 64'd0);
        checkOutput("abort_data", 64'(data_out), 64'd0);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        checkOutput("post_rst_read_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("post_rst_read_valid", 64'(out_valid), 64'd0);

        $display("[TB] memory survives reset");
        doLoad(4, 3, 2'b10, 1'b1);
        doRead(1);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
